// File: rtl/sram_ctrl.sv
// sram_ctrl: single-port sequencer for an external asynchronous 16-bit SRAM.
// Accepts one start/rw/addr/wdata request at a time and walks the SRAM pins
// through setup, access and hold phases whose lengths are set by parameters.
// Every pin and the data-bus drive enable comes straight from a flop.
module sram_ctrl #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int SETUP_CYC  = 1,
  parameter int ACCESS_CYC = 2,
  parameter int HOLD_CYC   = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              rw,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_dq,
  output logic              mem_ce_n,
  output logic              mem_oe_n,
  output logic              mem_we_n,
  output logic              mem_ub_n,
  output logic              mem_lb_n
);

  localparam int CNT_W = 16;
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] ACCESS_LD = CNT_W'(ACCESS_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS, HOLD} state_t;

  state_t             r_state;
  state_t             w_stateNext;
  logic [CNT_W-1:0]   r_cnt;
  logic [CNT_W-1:0]   w_cntNext;

  logic               r_rw;
  logic [ADDR_W-1:0]  r_addr;
  logic [DATA_W-1:0]  r_wdata;
  logic [DATA_W-1:0]  r_rdata;

  logic               r_ready;
  logic [ADDR_W-1:0]  r_memAddr;
  logic [DATA_W-1:0]  r_dqOut;
  logic               r_dqOe;
  logic               r_ceN;
  logic               r_oeN;
  logic               r_weN;
  logic               r_byteN;

  logic               w_accept;
  logic               w_capture;
  logic               w_reqRw;
  logic [ADDR_W-1:0]  w_reqAddr;
  logic [DATA_W-1:0]  w_reqWdata;
  logic               w_ready;
  logic [ADDR_W-1:0]  w_memAddr;
  logic [DATA_W-1:0]  w_dqOut;
  logic               w_dqOe;
  logic               w_ceN;
  logic               w_oeN;
  logic               w_weN;
  logic               w_byteN;

  // A request is taken only while idle; the pin values for the first SETUP
  // cycle must see the incoming request, later phases use the latched copy.
  assign w_accept   = (r_state == IDLE) && start;
  assign w_reqRw    = w_accept ? rw    : r_rw;
  assign w_reqAddr  = w_accept ? addr  : r_addr;
  assign w_reqWdata = w_accept ? wdata : r_wdata;
  assign w_capture  = (r_state == ACCESS) && (r_cnt == '0) && r_rw;

  assign rdata    = r_rdata;
  assign ready    = r_ready;
  assign mem_addr = r_memAddr;
  assign mem_ce_n = r_ceN;
  assign mem_oe_n = r_oeN;
  assign mem_we_n = r_weN;
  assign mem_ub_n = r_byteN;
  assign mem_lb_n = r_byteN;
  assign mem_dq   = r_dqOe ? r_dqOut : {DATA_W{1'bz}};

  // State register and phase counter; reset drops straight back to IDLE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
    end else begin
      r_state <= w_stateNext;
      r_cnt   <= w_cntNext;
    end
  end

  // Phase sequencing: each phase reloads the counter and exits when it hits zero.
  always_comb begin
    w_stateNext = r_state;
    w_cntNext   = r_cnt;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_stateNext = SETUP;
          w_cntNext   = SETUP_LD;
        end
      end
      SETUP: begin
        if (r_cnt == '0) begin
          w_stateNext = ACCESS;
          w_cntNext   = ACCESS_LD;
        end else begin
          w_cntNext = r_cnt - 1'b1;
        end
      end
      ACCESS: begin
        if (r_cnt == '0) begin
          w_stateNext = HOLD;
          w_cntNext   = HOLD_LD;
        end else begin
          w_cntNext = r_cnt - 1'b1;
        end
      end
      HOLD: begin
        if (r_cnt == '0) begin
          w_stateNext = IDLE;
          w_cntNext   = '0;
        end else begin
          w_cntNext = r_cnt - 1'b1;
        end
      end
      default: begin
        w_stateNext = IDLE;
        w_cntNext   = '0;
      end
    endcase
  end

  // Pin values for the coming cycle, decoded from the state being entered.
  always_comb begin
    w_ready   = 1'b0;
    w_ceN     = 1'b1;
    w_oeN     = 1'b1;
    w_weN     = 1'b1;
    w_byteN   = 1'b1;
    w_dqOe    = 1'b0;
    w_memAddr = r_memAddr;
    w_dqOut   = r_dqOut;
    case (w_stateNext)
      IDLE: begin
        w_ready = 1'b1;
      end
      SETUP, HOLD: begin
        w_ceN     = 1'b0;
        w_byteN   = 1'b0;
        w_memAddr = w_reqAddr;
        w_dqOut   = w_reqWdata;
        w_dqOe    = ~w_reqRw;
      end
      ACCESS: begin
        w_ceN     = 1'b0;
        w_byteN   = 1'b0;
        w_memAddr = w_reqAddr;
        w_dqOut   = w_reqWdata;
        w_dqOe    = ~w_reqRw;
        if (w_reqRw) begin
          w_oeN = 1'b0;
        end else begin
          w_weN = 1'b0;
        end
      end
      default: begin
        w_ready = 1'b0;
      end
    endcase
  end

  // Pin register: reset parks every strobe high and floats the data bus at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ready   <= 1'b1;
      r_memAddr <= '0;
      r_dqOut   <= '0;
      r_dqOe    <= 1'b0;
      r_ceN     <= 1'b1;
      r_oeN     <= 1'b1;
      r_weN     <= 1'b1;
      r_byteN   <= 1'b1;
    end else begin
      r_ready   <= w_ready;
      r_memAddr <= w_memAddr;
      r_dqOut   <= w_dqOut;
      r_dqOe    <= w_dqOe;
      r_ceN     <= w_ceN;
      r_oeN     <= w_oeN;
      r_weN     <= w_weN;
      r_byteN   <= w_byteN;
    end
  end

  // Request latch so input changes after acceptance cannot disturb the access.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rw    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
    end else if (w_accept) begin
      r_rw    <= rw;
      r_addr  <= addr;
      r_wdata <= wdata;
    end
  end

  // Read data is sampled on the final strobe edge and held until the next read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rdata <= '0;
    end else if (w_capture) begin
      r_rdata <= mem_dq;
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl: scoreboard bench for sram_ctrl with a behavioural async SRAM.
// Requests push their expected response; a negedge monitor checks the pin
// sequence of the access in flight and pops/compares when ready returns.
module tb_sram_ctrl;

  localparam int SETUP_N  = 1;
  localparam int ACCESS_N = 2;
  localparam int HOLD_N   = 1;
  localparam int TOTAL_N  = SETUP_N + ACCESS_N + HOLD_N;

  typedef struct {
    logic        isWrite;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] expRdata;
  } txn_t;

  logic        clk = 1'b0;
  logic        rstN;
  logic        start;
  logic        rw;
  logic [15:0] addr;
  logic [15:0] wdata;
  logic [15:0] rdata;
  logic        ready;
  logic [15:0] memAddr;
  wire  [15:0] memDq;
  logic        ceN;
  logic        oeN;
  logic        weN;
  logic        ubN;
  logic        lbN;

  logic [15:0] sram [0:65535];
  logic [15:0] latAddr;
  logic [15:0] latData;

  txn_t scoreQ[$];
  int   checks = 0;
  int   errors = 0;
  int   busy = 0;
  int   busyTotal = 0;
  int   weRun = 0;
  int   oeRun = 0;
  int   writeCount = 0;
  int   readCount = 0;

  sram_ctrl #(
    .ADDR_W(16), .DATA_W(16),
    .SETUP_CYC(SETUP_N), .ACCESS_CYC(ACCESS_N), .HOLD_CYC(HOLD_N)
  ) dut (
    .clk(clk), .rst_n(rstN), .start(start), .rw(rw), .addr(addr), .wdata(wdata),
    .rdata(rdata), .ready(ready), .mem_addr(memAddr), .mem_dq(memDq),
    .mem_ce_n(ceN), .mem_oe_n(oeN), .mem_we_n(weN), .mem_ub_n(ubN), .mem_lb_n(lbN)
  );

  // The SRAM drives the bus only during a read strobe.
  assign memDq = (!ceN && !oeN && weN) ? sram[memAddr] : 16'hzzzz;

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Issue one request when idle and record what its completion should show.
  task automatic applyStimulus(input logic isRead, input logic [15:0] a,
                               input logic [15:0] d, input logic [15:0] expRd);
    txn_t t;
    bit   gotReady = 0;
    for (int n = 0; n < 50; n++) begin
      @(negedge clk);
      if (ready) begin
        gotReady = 1;
        break;
      end
    end
    if (!gotReady) begin
      checks++;
      errors++;
      $display("[TB] FAIL readyTimeout: got 0 expected 1 at %0t", $time);
    end
    t.isWrite  = ~isRead;
    t.addr     = a;
    t.wdata    = d;
    t.expRdata = expRd;
    scoreQ.push_back(t);
    start = 1'b1;
    rw    = isRead;
    addr  = a;
    wdata = d;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic waitIdle();
    bit done = 0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      #1;
      if (ready && scoreQ.size() == 0) begin
        done = 1;
        break;
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("[TB] FAIL idleTimeout: got busy expected idle at %0t", $time);
    end
  endtask

  // Monitor: SRAM write/read bookkeeping, per-cycle pin checks, response pop.
  always @(negedge clk) begin
    txn_t cur;
    logic [5:0] expPins;
    bit inStrobe;
    if (!rstN) begin
      scoreQ.delete();
      busy  = 0;
      weRun = 0;
      oeRun = 0;
    end else begin
      if (!weN) begin
        weRun++;
        latAddr = memAddr;
        latData = memDq;
      end else begin
        if (weRun == ACCESS_N) begin
          sram[latAddr] = latData;
          writeCount++;
        end
        weRun = 0;
      end
      if (!oeN) oeRun++;
      else begin
        if (oeRun == ACCESS_N) readCount++;
        oeRun = 0;
      end

      if (ready) begin
        checkOutput("idlePins", 32'({ceN, oeN, weN, ubN, lbN, dut.r_dqOe}), 32'h3E);
        if (busy > 0) begin
          if (scoreQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpectedResponse: got response expected none at %0t", $time);
          end else begin
            cur = scoreQ.pop_front();
            checkOutput("busyCycles", 32'(busy), 32'(TOTAL_N));
            checkOutput("rdata", 32'(rdata), 32'(cur.expRdata));
          end
          busy = 0;
        end
      end else begin
        busy++;
        busyTotal++;
        if (scoreQ.size() == 0) begin
          if (busy == 1) begin
            checks++;
            errors++;
            $display("[TB] FAIL busyWithoutRequest: got busy expected idle at %0t", $time);
          end
        end else begin
          cur = scoreQ[0];
          inStrobe = (busy > SETUP_N) && (busy <= SETUP_N + ACCESS_N);
          // {ce_n, oe_n, we_n, ub_n, lb_n, dq drive}
          expPins = {1'b0, ~(inStrobe && !cur.isWrite), ~(inStrobe && cur.isWrite),
                     1'b0, 1'b0, cur.isWrite};
          checkOutput("busyPins", 32'({ceN, oeN, weN, ubN, lbN, dut.r_dqOe}), 32'(expPins));
          checkOutput("memAddr", 32'(memAddr), 32'(cur.addr));
          if (cur.isWrite) checkOutput("writeDq", 32'(memDq), 32'(cur.wdata));
        end
        if (busy == TOTAL_N + 1) begin
          checks++;
          errors++;
          $display("[TB] FAIL stuckBusy: got %0d busy cycles expected %0d", busy, TOTAL_N);
        end
      end
    end
  end

  initial begin
    int  mark;
    bit  sawWe;
    rstN  = 1'b0;
    start = 1'b0;
    rw    = 1'b0;
    addr  = '0;
    wdata = '0;
    for (int i = 0; i < 65536; i++) sram[i] = 16'h0000;

    // Reset state
    #12;
    checkOutput("rstReady", 32'(ready), 32'd1);
    checkOutput("rstRdata", 32'(rdata), 32'd0);
    checkOutput("rstMemAddr", 32'(memAddr), 32'd0);
    checkOutput("rstPins", 32'({ceN, oeN, weN, ubN, lbN, dut.r_dqOe}), 32'h3E);
    @(negedge clk);
    rstN = 1'b1;

    // Write then read back; a following write must leave rdata alone
    applyStimulus(1'b0, 16'h1234, 16'hBEEF, 16'h0000);
    applyStimulus(1'b1, 16'h1234, 16'h0000, 16'hBEEF);
    applyStimulus(1'b0, 16'h0040, 16'h7777, 16'hBEEF);

    // Start pulsed while busy with new addr/data must be ignored
    applyStimulus(1'b0, 16'h0020, 16'h5555, 16'hBEEF);
    @(negedge clk);
    start = 1'b1;
    rw    = 1'b0;
    addr  = 16'h0001;
    wdata = 16'hDEAD;
    @(posedge clk);
    #1 start = 1'b0;
    waitIdle();

    // Back-to-back write and read: 8 busy cycles in total
    mark = busyTotal;
    applyStimulus(1'b0, 16'h0010, 16'hAAAA, 16'hBEEF);
    applyStimulus(1'b1, 16'h0010, 16'h0000, 16'hAAAA);
    waitIdle();
    checkOutput("b2bBusyTotal", 32'(busyTotal - mark), 32'(2 * TOTAL_N));

    // Reset during write strobe aborts immediately
    applyStimulus(1'b0, 16'h2222, 16'h9999, 16'hAAAA);
    sawWe = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (!weN) begin
        sawWe = 1;
        break;
      end
    end
    checkOutput("sawWriteStrobe", 32'(sawWe), 32'd1);
    #2 rstN = 1'b0;
    #1;
    checkOutput("abortWeN", 32'(weN), 32'd1);
    checkOutput("abortCeN", 32'(ceN), 32'd1);
    checkOutput("abortDqDrive", 32'(dut.r_dqOe), 32'd0);
    checkOutput("abortReady", 32'(ready), 32'd1);
    repeat (2) @(negedge clk);
    rstN = 1'b1;
    #1;
    checkOutput("rdataAfterReset", 32'(rdata), 32'd0);
    applyStimulus(1'b1, 16'h2222, 16'h0000, 16'h0000);
    waitIdle();

    // SRAM model log
    checkOutput("writeCount", 32'(writeCount), 32'd4);
    checkOutput("readCount", 32'(readCount), 32'd3);
    checkOutput("ignoredAddrUntouched", 32'(sram[16'h0001]), 32'd0);
    checkOutput("abortedAddrUntouched", 32'(sram[16'h2222]), 32'd0);
    checkOutput("sramAt0040", 32'(sram[16'h0040]), 32'h7777);
    checkOutput("sramAt0020", 32'(sram[16'h0020]), 32'h5555);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
